ysyx_23060201_mem_arbiter: RTL and testbench
============================================

# ysyx_23060201_mem_arbiter

Two-master, one-slave arbiter sharing the single core memory port between instruction fetch (IFU) and load/store (LSU) in the multi-cycle NPC. Each master issues valid/ready requests; the arbiter grants one at a time round-robin, forwards the transaction to memory, waits for the memory response and returns it, registered, to the owning master. Only one transaction is outstanding at a time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; mask width is DATA_W/8
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_rsp_valid  out  1  one-cycle pulse, IFU read data valid
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte write mask
- lsu_rsp_valid  out  1  one-cycle pulse, LSU read data / write ack
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_rsp_valid  in  1  memory response (read data or write ack)
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- owner  out  1  0 = IFU, 1 = LSU; owner of current/last transaction

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: grant computed combinationally. Only one valid -> that master. Both valid -> master != last_owner (round-robin). Granted master's req_ready = 1; other req_ready = 0. No valid -> both ready 0, stay IDLE.
- On accept edge: latch addr/wen/wdata/wmask (IFU forces wen=0, wmask=0, wdata=0), owner <= granted, last_owner <= granted, state -> REQ.
- REQ: mem_req_valid = 1 with latched fields, stable until mem_req_ready; on handshake edge -> WAIT. req_ready = 0 for both masters outside IDLE.
- WAIT: on mem_rsp_valid edge: register mem_rdata into owner's rdata, pulse owner's rsp_valid for exactly one cycle, state -> IDLE. Non-owner rsp_valid stays 0.
- mem_rsp_valid in IDLE or REQ: ignored, no state change, no output pulse.
- Writes: LSU receives lsu_rsp_valid as ack; lsu_rdata carries mem_rdata unmodified (don't-care).
- rdata outputs hold their last value between responses.
- No response backpressure: masters must take rsp_valid the cycle it is high.

## Timing
- Reset (async): state IDLE, owner 0, last_owner 1 (first conflict goes to IFU), all valid/ready outputs 0, mem_* fields 0, ifu_rdata/lsu_rdata 0, busy 0.
- Reset mid-transaction: in-flight transaction dropped, no rsp pulse; memory-side cleanup is the memory's responsibility.
- Cycle 0: req_valid & req_ready (IDLE). Cycle 1: mem_req_valid = 1. If mem_req_ready in cycle 1 -> cycle 2 WAIT. If mem_rsp_valid in cycle 2 -> cycle 3 rsp_valid = 1, state IDLE, new grant possible in cycle 3.
- Minimum request-to-response latency 3 cycles; back-to-back throughput one transaction per 3 cycles.
- rsp_valid and next req_ready may be high in the same cycle.
- busy = 1 in REQ and WAIT, 0 in IDLE.

## Test plan
- Reset: assert rst mid-WAIT -> all valid/ready, busy, rdata = 0 immediately (asynchronous); after release, IFU single read addr 0x80000000 granted first cycle.
- Single IFU read: ifu_req_valid, addr 0x80000004, mem ready same cycle, rsp next cycle with 0x00100093 -> ifu_rsp_valid pulse exactly cycle 3, ifu_rdata = 0x00100093, lsu_rsp_valid stays 0.
- LSU write: addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011 -> mem_wen=1, mem_wmask=4'b0011, mem_wdata=0xDEADBEEF held during REQ; lsu_rsp_valid pulse on ack.
- Conflict round-robin: both valid continuously out of reset -> grant order IFU, LSU, IFU, LSU over four transactions; owner toggles accordingly.
- Memory stalls: mem_req_ready low 5 cycles, then mem_rsp_valid delayed 4 cycles -> mem_* fields stable throughout, req_ready 0 for both masters, busy 1, single rsp pulse.
- Spurious mem_rsp_valid in IDLE and in REQ -> no rsp pulse, no state change, rdata unchanged.

Source files
------------

// File: rtl/ysyx_23060201_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU masters, the arbiter and the memory port.
// slave: arbiter view (masters and memory drive it); master: environment view.
interface ysyx_23060201_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rsp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_rsp_valid;
  logic [DATA_W-1:0]   lsu_rdata;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen,
    input  lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen,
    output mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen,
    output lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen,
    input  mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto the single memory port, one txn in flight.
// Ports: clk, rst (async high), bus (slave modport), busy, owner (0=IFU).
module ysyx_23060201_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  ysyx_23060201_mem_arbiter_if.slave bus,
  output logic busy,
  output logic owner
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]          r_state;
  logic                r_owner;
  logic                r_last;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic                r_ifu_rsp;
  logic                r_lsu_rsp;
  logic [DATA_W-1:0]   r_ifu_rdata;
  logic [DATA_W-1:0]   r_lsu_rdata;

  logic w_idle;
  logic w_gnt_lsu;
  logic w_acc;

  assign w_idle = (r_state == S_IDLE);

  // LSU wins when alone, or on conflict when IFU owned the last txn.
  assign w_gnt_lsu = bus.lsu_req_valid &
                     (~bus.ifu_req_valid | ~r_last);
  assign w_acc = w_idle &
                 (bus.ifu_req_valid | bus.lsu_req_valid);

  assign bus.ifu_req_ready = w_idle & bus.ifu_req_valid &
                             ~w_gnt_lsu;
  assign bus.lsu_req_ready = w_idle & w_gnt_lsu;

  assign bus.mem_req_valid = (r_state == S_REQ);
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wen       = r_wen;
  assign bus.mem_wdata     = r_wdata;
  assign bus.mem_wmask     = r_wmask;

  assign bus.ifu_rsp_valid = r_ifu_rsp;
  assign bus.ifu_rdata     = r_ifu_rdata;
  assign bus.lsu_rsp_valid = r_lsu_rsp;
  assign bus.lsu_rdata     = r_lsu_rdata;

  assign busy  = ~w_idle;
  assign owner = r_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_ifu_rsp   <= 1'b0;
      r_lsu_rsp   <= 1'b0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
    end else begin
      r_ifu_rsp <= 1'b0;
      r_lsu_rsp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            // IFU is read-only: write fields forced to zero.
            r_addr  <= w_gnt_lsu ? bus.lsu_addr : bus.ifu_addr;
            r_wen   <= w_gnt_lsu & bus.lsu_wen;
            r_wdata <= w_gnt_lsu ? bus.lsu_wdata : '0;
            r_wmask <= w_gnt_lsu ? bus.lsu_wmask : '0;
            r_owner <= w_gnt_lsu;
            r_last  <= w_gnt_lsu;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (r_owner) begin
              r_lsu_rdata <= bus.mem_rdata;
              r_lsu_rsp   <= 1'b1;
            end else begin
              r_ifu_rdata <= bus.mem_rdata;
              r_ifu_rsp   <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter with a latency-programmable
// memory model; all checks go through chk().
module tb_ysyx_23060201_mem_arbiter;
  typedef struct {
    logic        own;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic owner;

  ysyx_23060201_mem_arbiter_if bus ();

  ysyx_23060201_mem_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int n_ifu  = 0;
  int n_lsu  = 0;

  exp_t exp_q[$];
  logic gnt_q[$];

  int          req_lat = 0;
  int          rsp_lat = 0;
  int          scnt    = 0;
  int          wcnt    = 0;
  logic        pend    = 1'b0;
  logic        hold    = 1'b0;
  logic        spur    = 1'b0;
  logic [31:0] paddr   = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == 32'h8000_0004) ? 32'h0010_0093
                                : (a ^ 32'h1234_5678);
  endfunction

  // Memory model: evaluated mid-cycle, drives ready/rsp for this cycle.
  task automatic mdl();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = spur;
    if (spur) bus.mem_rdata = 32'hBAD0_BAD0;
    if (rst) begin
      pend = 1'b0;
      scnt = 0;
      wcnt = 0;
    end else if (pend) begin
      if (wcnt < rsp_lat) wcnt++;
      else begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = memfn(paddr);
        pend              = 1'b0;
      end
    end else if (bus.mem_req_valid && !hold) begin
      if (scnt < req_lat) scnt++;
      else begin
        bus.mem_req_ready = 1'b1;
        pend  = 1'b1;
        paddr = bus.mem_addr;
        scnt  = 0;
        wcnt  = 0;
      end
    end
  endtask

  task automatic mon_acc();
    if (rst) return;
    if (bus.ifu_req_valid && bus.ifu_req_ready) begin
      exp_q.push_back('{own: 1'b0, data: memfn(bus.ifu_addr)});
      gnt_q.push_back(1'b0);
    end
    if (bus.lsu_req_valid && bus.lsu_req_ready) begin
      exp_q.push_back('{own: 1'b1, data: memfn(bus.lsu_addr)});
      gnt_q.push_back(1'b1);
    end
  endtask

  task automatic mon_rsp();
    exp_t e;
    logic [31:0] d;
    if (rst) begin
      exp_q.delete();
      return;
    end
    if (bus.ifu_rsp_valid) n_ifu++;
    if (bus.lsu_rsp_valid) n_lsu++;
    if (bus.ifu_rsp_valid && bus.lsu_rsp_valid)
      chk("dual_rsp", 64'(bus.lsu_rsp_valid), 64'(!bus.ifu_rsp_valid));
    if (bus.ifu_rsp_valid || bus.lsu_rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        d = bus.lsu_rsp_valid ? bus.lsu_rdata : bus.ifu_rdata;
        chk("rsp_who", 64'(bus.lsu_rsp_valid), 64'(e.own));
        chk("rsp_owner", 64'(owner), 64'(e.own));
        chk("rsp_data", 64'(d), 64'(e.data));
      end
    end
  endtask

  // Main sits at the falling edge; inputs set there, model/monitors run here.
  task automatic nxt();
    #1;
    mdl();
    mon_acc();
    @(negedge clk);
    mon_rsp();
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < n) begin
      nxt();
      k++;
    end
    chk("timeout", 64'(exp_q.size()) | 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_ifu;
    int p_lsu;
    int k;
    int nreq;
    int nwait;
    int bad;

    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;

    @(negedge clk);
    nxt();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_mreq", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_maddr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mwdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_irdy", 64'(bus.ifu_req_ready), 64'd0);
    chk("rst_irsp", 64'(bus.ifu_rsp_valid), 64'd0);
    chk("rst_irdata", 64'(bus.ifu_rdata), 64'd0);
    chk("rst_lrdata", 64'(bus.lsu_rdata), 64'd0);
    rst = 1'b0;
    nxt();

    // single IFU read, minimum latency
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0004;
    #1;
    chk("c0_irdy", 64'(bus.ifu_req_ready), 64'd1);
    chk("c0_lrdy", 64'(bus.lsu_req_ready), 64'd0);
    nxt();
    bus.ifu_req_valid = 1'b0;
    chk("c1_mreq", 64'(bus.mem_req_valid), 64'd1);
    chk("c1_maddr", 64'(bus.mem_addr), 64'h8000_0004);
    chk("c1_mwen", 64'(bus.mem_wen), 64'd0);
    chk("c1_busy", 64'(busy), 64'd1);
    chk("c1_irdy", 64'(bus.ifu_req_ready), 64'd0);
    nxt();
    chk("c2_mreq", 64'(bus.mem_req_valid), 64'd0);
    chk("c2_busy", 64'(busy), 64'd1);
    chk("c2_irsp", 64'(bus.ifu_rsp_valid), 64'd0);
    nxt();
    chk("c3_irsp", 64'(bus.ifu_rsp_valid), 64'd1);
    chk("c3_irdata", 64'(bus.ifu_rdata), 64'h0010_0093);
    chk("c3_lrsp", 64'(bus.lsu_rsp_valid), 64'd0);
    chk("c3_busy", 64'(busy), 64'd0);
    nxt();
    chk("c4_irsp", 64'(bus.ifu_rsp_valid), 64'd0);
    chk("c4_irdata", 64'(bus.ifu_rdata), 64'h0010_0093);

    // LSU write held in REQ across a short stall
    req_lat = 2;
    p_ifu   = n_ifu;
    p_lsu   = n_lsu;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wmask     = 4'b0011;
    nxt();
    bus.lsu_req_valid = 1'b0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_mreq", 64'(bus.mem_req_valid), 64'd1);
      chk("wr_mwen", 64'(bus.mem_wen), 64'd1);
      chk("wr_mwmask", 64'(bus.mem_wmask), 64'h3);
      chk("wr_mwdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
      nxt();
    end
    wait_done(20);
    chk("wr_lsu_ack", 64'(n_lsu - p_lsu), 64'd1);
    chk("wr_ifu_none", 64'(n_ifu - p_ifu), 64'd0);
    req_lat = 0;

    // round-robin under continuous conflict out of reset
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    gnt_q.delete();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0100;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_2000;
    k = 0;
    while (gnt_q.size() < 4 && k < 40) begin
      nxt();
      k++;
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    wait_done(20);
    chk("rr_cnt", 64'(gnt_q.size()), 64'd4);
    chk("rr_cycles", 64'(k), 64'd10);
    if (gnt_q.size() >= 4) begin
      chk("rr_g0", 64'(gnt_q[0]), 64'd0);
      chk("rr_g1", 64'(gnt_q[1]), 64'd1);
      chk("rr_g2", 64'(gnt_q[2]), 64'd0);
      chk("rr_g3", 64'(gnt_q[3]), 64'd1);
    end

    // long memory stalls with LSU waiting behind the IFU
    req_lat = 5;
    rsp_lat = 4;
    p_ifu   = n_ifu;
    p_lsu   = n_lsu;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0200;
    nxt();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_3000;
    nreq  = 0;
    nwait = 0;
    bad   = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.ifu_rsp_valid) break;
      if (bus.mem_req_valid) nreq++;
      else nwait++;
      if (bus.mem_addr != 32'h8000_0200 || bus.mem_wen ||
          bus.mem_wmask != 4'h0 || bus.ifu_req_ready ||
          bus.lsu_req_ready || !busy)
        bad++;
      nxt();
    end
    chk("st_req_cyc", 64'(nreq), 64'd6);
    chk("st_wait_cyc", 64'(nwait), 64'd5);
    chk("st_stable", 64'(bad), 64'd0);
    chk("st_irsp", 64'(bus.ifu_rsp_valid), 64'd1);
    chk("st_lrdy_same", 64'(bus.lsu_req_ready), 64'd1);
    req_lat = 0;
    rsp_lat = 0;
    nxt();
    bus.lsu_req_valid = 1'b0;
    wait_done(20);
    chk("st_ifu_pulses", 64'(n_ifu - p_ifu), 64'd1);
    chk("st_lsu_pulses", 64'(n_lsu - p_lsu), 64'd1);

    // spurious response in IDLE
    p_ifu = n_ifu;
    p_lsu = n_lsu;
    spur  = 1'b1;
    nxt();
    spur = 1'b0;
    chk("sp0_busy", 64'(busy), 64'd0);
    chk("sp0_irsp", 64'(bus.ifu_rsp_valid), 64'd0);
    chk("sp0_lrsp", 64'(bus.lsu_rsp_valid), 64'd0);
    chk("sp0_owner", 64'(owner), 64'd1);
    chk("sp0_irdata", 64'(bus.ifu_rdata), 64'(memfn(32'h8000_0200)));
    chk("sp0_lrdata", 64'(bus.lsu_rdata), 64'(memfn(32'h8000_3000)));

    // spurious response in REQ
    hold = 1'b1;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0300;
    nxt();
    bus.ifu_req_valid = 1'b0;
    spur = 1'b1;
    nxt();
    spur = 1'b0;
    hold = 1'b0;
    chk("sp1_mreq", 64'(bus.mem_req_valid), 64'd1);
    chk("sp1_irsp", 64'(bus.ifu_rsp_valid), 64'd0);
    chk("sp1_irdata", 64'(bus.ifu_rdata), 64'(memfn(32'h8000_0200)));
    wait_done(20);
    chk("sp1_done", 64'(bus.ifu_rdata), 64'(memfn(32'h8000_0300)));
    chk("sp_ifu_pulses", 64'(n_ifu - p_ifu), 64'd1);
    chk("sp_lsu_pulses", 64'(n_lsu - p_lsu), 64'd0);

    // asynchronous reset in WAIT drops the transaction
    rsp_lat = 5;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0400;
    nxt();
    bus.ifu_req_valid = 1'b0;
    k = 0;
    while (bus.mem_req_valid && k < 10) begin
      nxt();
      k++;
    end
    chk("rw_in_wait", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_mreq", 64'(bus.mem_req_valid), 64'd0);
    chk("rw_owner", 64'(owner), 64'd0);
    chk("rw_irdata", 64'(bus.ifu_rdata), 64'd0);
    chk("rw_lrdata", 64'(bus.lsu_rdata), 64'd0);
    chk("rw_irsp", 64'(bus.ifu_rsp_valid), 64'd0);
    p_ifu = n_ifu;
    nxt();
    nxt();
    rst     = 1'b0;
    rsp_lat = 0;
    for (int i = 0; i < 4; i++) nxt();
    chk("rw_no_pulse", 64'(n_ifu - p_ifu), 64'd0);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    #1;
    chk("rw_irdy", 64'(bus.ifu_req_ready), 64'd1);
    nxt();
    bus.ifu_req_valid = 1'b0;
    wait_done(20);
    chk("rw_irdata2", 64'(bus.ifu_rdata), 64'(memfn(32'h8000_0000)));
    chk("rw_pulse", 64'(n_ifu - p_ifu), 64'd1);

    nxt();
    chk("sb_final", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
